pwm_duty_capture: RTL and testbench

- Measures an external PWM input, such as an RC receiver or throttle channel, in clk cycles.
- Publishes a stable 32-bit high-time word and period word.
- duty_out connects directly to the in_port of the Nios duty-input PIO (readdata at offset 0). period_out and signal_lost feed neighbouring PIOs.
- Outputs change only on a completed rising-to-rising PWM cycle, or on loss of signal.

---
 rtl/pwm_duty_capture.sv | 120 ++++++++++++
 tb/tb_pwm_duty_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// PWM input capture: synchronises pwm_in and measures high time and
// rising-to-rising period in clk cycles, with loss-of-signal timeout.
module pwm_duty_capture #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [31:0] duty_out,
    output logic [31:0] period_out,
    output logic        valid,
    output logic        signal_lost
);

    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT_RISE,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_timeout;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_high_lat;
    logic [31:0] r_duty;
    logic [31:0] r_period;
    logic        r_valid;
    logic        r_lost;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_timeout = (r_cnt >= LP_TIMEOUT);

    // Reset to 1 so a line held high out of reset never looks like a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_s_d  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        if (reset) begin
            r_state    <= ST_WAIT_RISE;
            r_cnt      <= '0;
            r_high_lat <= '0;
            r_duty     <= '0;
            r_period   <= '0;
            r_lost     <= 1'b1;
        end else begin
            case (r_state)
                ST_WAIT_RISE: begin
                    if (r_rise) begin
                        r_cnt   <= 32'd1;
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (r_fall) begin
                        r_high_lat <= r_cnt;
                        r_cnt      <= r_cnt + 32'd1;
                        r_state    <= ST_LOW;
                    end else if (w_timeout) begin
                        r_duty   <= '0;
                        r_period <= '0;
                        r_lost   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_LOW: begin
                    if (r_rise) begin
                        r_duty   <= r_high_lat;
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        r_lost   <= 1'b0;
                        r_cnt    <= 32'd1;
                        r_state  <= ST_HIGH;
                    end else if (w_timeout) begin
                        r_duty   <= '0;
                        r_period <= '0;
                        r_lost   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_RISE;
                end
            endcase
        end
    end

    assign duty_out    = r_duty;
    assign period_out  = r_period;
    assign valid       = r_valid;
    assign signal_lost = r_lost;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: timestamp-based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_pwm_duty_capture;

    localparam int T = 2000;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] duty_out;
    logic [31:0] period_out;
    logic        valid;
    logic        signal_lost;

    pwm_duty_capture #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pwm_in(pwm_in),
        .duty_out(duty_out),
        .period_out(period_out),
        .valid(valid),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Input values as seen by the DUT at each rising edge.
    logic e_pwm = 1'b0;
    logic e_rst = 1'b1;
    always @(posedge clk) begin
        e_pwm <= pwm_in;
        e_rst <= reset;
    end

    // Model: edges are the sampled input delayed S+1 edges; measurements
    // are differences of edge timestamps.
    bit          q[$];
    int          mode = 0;
    longint      n = 0;
    longint      tr = 0;
    longint      hl = 0;
    logic [31:0] m_duty = '0;
    logic [31:0] m_period = '0;
    bit          m_valid = 1'b0;
    bit          m_lost = 1'b1;
    bit          m_init = 1'b0;
    bit          prev_pwm = 1'b1;
    bit   [15:0] rbuf = '0;
    int          vcount = 0;

    always @(negedge clk) begin
        bit rise;
        bit fall;
        n++;
        rbuf[int'(n % 16)] = e_pwm && !prev_pwm && !e_rst;
        prev_pwm = e_pwm;
        m_valid = 1'b0;
        if (e_rst) begin
            q.delete();
            repeat (S + 2) q.push_back(1'b1);
            mode = 0;
            hl = 0;
            m_duty = '0;
            m_period = '0;
            m_lost = 1'b1;
            m_init = 1'b1;
            prev_pwm = 1'b1;
        end else if (m_init) begin
            q.push_back(e_pwm);
            rise = q[1] && !q[0];
            fall = !q[1] && q[0];
            void'(q.pop_front());
            if (mode == 0) begin
                if (rise) begin
                    mode = 1;
                    tr = n;
                end
            end else if (mode == 1 && fall) begin
                hl = n - tr;
                mode = 2;
            end else if (mode == 2 && rise) begin
                m_duty = 32'(hl);
                m_period = 32'(n - tr);
                m_valid = 1'b1;
                m_lost = 1'b0;
                tr = n;
                mode = 1;
            end else if (n - tr >= T) begin
                m_duty = '0;
                m_period = '0;
                m_lost = 1'b1;
                mode = 0;
            end
        end
        if (m_init) begin
            chk("duty", duty_out, m_duty);
            chk("period", period_out, m_period);
            chk("valid", valid, m_valid);
            chk("lost", signal_lost, m_lost);
            if (valid === 1'b1) begin
                vcount++;
                chk("latency", rbuf[int'((n - S - 1) % 16)], 1);
            end
        end
    end

    task automatic hold(input logic v, input int c);
        pwm_in = v;
        repeat (c) @(negedge clk);
    endtask

    task automatic train(input int h, input int l, input int p);
        repeat (p) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int v0;
        int h;
        int l;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        v0 = vcount;
        hold(1'b0, 50);
        chk("rst0_duty", duty_out, 0);
        chk("rst0_period", period_out, 0);
        chk("rst0_lost", signal_lost, 1);
        pwm_in = 1'b1;
        pulse_reset();
        hold(1'b1, 50);
        chk("rst1_lost", signal_lost, 1);
        chk("rst_novalid", vcount - v0, 0);

        hold(1'b0, 20);
        v0 = vcount;
        train(75, 925, 5);
        chk("s2_count", vcount - v0, 4);
        chk("s2_duty", duty_out, 75);
        chk("s2_period", period_out, 1000);
        chk("s2_lost", signal_lost, 0);

        v0 = vcount;
        train(120, 880, 3);
        chk("s3_count", vcount - v0, 3);
        chk("s3_duty", duty_out, 120);
        chk("s3_period", period_out, 1000);

        v0 = vcount;
        hold(1'b0, 2500);
        chk("s4_duty", duty_out, 0);
        chk("s4_period", period_out, 0);
        chk("s4_lost", signal_lost, 1);
        chk("s4_novalid", vcount - v0, 0);
        v0 = vcount;
        train(10, 10, 3);
        chk("s4_restart_count", vcount - v0, 2);
        chk("s4_restart_period", period_out, 20);
        hold(1'b0, 30);

        train(50, 50, 2);
        hold(1'b1, 3000);
        chk("s5_lost", signal_lost, 1);
        chk("s5_duty", duty_out, 0);
        v0 = vcount;
        hold(1'b0, 200);
        chk("s5_release_novalid", vcount - v0, 0);
        chk("s5_release_lost", signal_lost, 1);

        train(30, 30, 3);
        chk("s6_pre_duty", duty_out, 30);
        hold(1'b1, 43);
        pulse_reset();
        chk("s6_rst_duty", duty_out, 0);
        chk("s6_rst_period", period_out, 0);
        chk("s6_rst_lost", signal_lost, 1);
        hold(1'b0, 5);
        v0 = vcount;
        train(10, 10, 3);
        chk("s6_count", vcount - v0, 2);
        chk("s6_duty", duty_out, 10);
        chk("s6_period", period_out, 20);
        train(1, 1, 6);
        chk("min_duty", duty_out, 1);
        chk("min_period", period_out, 2);
        hold(1'b0, 10);

        repeat (25) begin
            h = int'($urandom_range(1, 60));
            l = int'($urandom_range(1, 60));
            train(h, l, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 7) == 0) pulse_reset();
            if ($urandom_range(0, 9) == 0) hold(1'b0, 2100);
        end
        hold(1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
